// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg -- shared definitions for the sequential restoring divider.
//
// Contents:
//   state_t            controller states (IDLE, CALC, DONE)
//   DIV_WIDTH_DEFAULT  default operand/quotient/remainder width
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH_DEFAULT = 16;

endpackage : div_pkg

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step -- one combinational restoring-division iteration.
//
// Shifts the next dividend bit (MSB of q) into the partial remainder, then
// subtracts the divisor if it fits and records the quotient bit in the LSB.
//
// Ports:
//   r       in   WIDTH+1  partial remainder
//   q       in   WIDTH    dividend/quotient shift register
//   d       in   WIDTH    divisor
//   r_next  out  WIDTH+1  updated partial remainder
//   q_next  out  WIDTH    updated dividend/quotient shift register
// ---------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] d_ext;

  assign d_ext = {1'b0, d};

  always_comb begin
    // NOTE: every output gets a default before the conditional update, so no
    // path leaves a value unassigned and no latch is inferred.
    r_shift = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
    r_next  = r_shift;
    q_next  = q << 1;
    if (r_shift >= d_ext) begin
      r_next    = r_shift - d_ext;
      q_next[0] = 1'b1;
    end
  end

endmodule : div_step

// File: rtl/div16_seq.sv
// ---------------------------------------------------------------------------
// div16_seq -- sequential unsigned restoring divider, one quotient bit per
// cycle, with valid/ready handshakes on the operand and result sides.
//
// A normal operation takes WIDTH CALC cycles; a zero divisor skips straight
// to DONE with quotient all-ones, remainder = dividend and div_by_zero set.
// Result registers change only on entry to DONE, so they hold the previous
// result at all other times.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous active-high reset
//   in_valid     in   1      operand pair valid
//   in_ready     out  1      divider idle, can accept operands
//   dividend     in   WIDTH  unsigned dividend
//   divisor      in   WIDTH  unsigned divisor
//   out_valid    out  1      result valid
//   out_ready    in   1      sink accepts result
//   quotient     out  WIDTH  floor(dividend / divisor)
//   remainder    out  WIDTH  dividend mod divisor
//   div_by_zero  out  1      result came from a zero divisor
// ---------------------------------------------------------------------------
module div16_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it only acts on a clock edge; it
    // overrides every handshake in the same cycle and discards any partial op.
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is the handshake.
          if (in_valid) begin
            d_reg    <= divisor;
            q_reg    <= dividend;
            r_reg    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= q_next;
            // The restoring step keeps the remainder below the divisor, so
            // the extra compare bit is always zero here.
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end

        DONE: begin
          // Results hold until the sink takes them; new operands are only
          // accepted from the following cycle.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule : div16_seq

// File: tb/tb_div16_seq.sv
// ---------------------------------------------------------------------------
// tb_div16_seq -- scoreboard bench for div16_seq.
//
// The stimulus side pushes the expected result (and its handshake cycle) into
// a queue on every accepted operand pair; an independent monitor checks the
// result latency on each rising out_valid and pops/compares on every result
// handshake. Inputs are driven 1 ns after the rising edge, outputs sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_div16_seq;
  import div_pkg::*;

  localparam int W = 16;
  localparam int LAT_CALC = W + 1;   // handshake cycle T -> out_valid at T+17
  localparam int LAT_DBZ  = 1;       // zero divisor -> out_valid at T+1

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  div16_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           t_hs;
    int           lat;
  } exp_t;

  exp_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;

  logic bp        = 1'b0;   // directed backpressure: hold out_ready low
  logic rand_mode = 1'b0;   // randomize out_ready every cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sink side: out_ready driven 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : !bp;
    end
  end

  // Monitor: latency on each rising out_valid, data on each result handshake.
  initial begin
    logic ov_prev;
    exp_t e;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
      end else begin
        if (out_valid && !ov_prev) begin
          if (sb.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
          else                check("latency", 32'(cyc - sb[0].t_hs), 32'(sb[0].lat));
        end
        if (out_valid && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          check("quotient", 32'(quotient), 32'(e.q));
          check("remainder", 32'(remainder), 32'(e.r));
          check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        end
        ov_prev = out_valid;
      end
    end
  end

  // Present one operand pair (called 1 ns after a rising edge) and hold it
  // until accepted; the expected result is queued in the handshake cycle.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    exp_t e;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.q    = eq;
        e.r    = er;
        e.dz   = edz;
        e.t_hs = cyc;
        e.lat  = edz ? LAT_DBZ : LAT_CALC;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  // Reference-model send for the random phase.
  task automatic send_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) send(a, b, '1, a, 1'b1);
    else         send(a, b, a / b, a % b, 1'b0);
  endtask

  // Wait for out_valid; optionally confirm in_ready stays low meanwhile.
  task automatic wait_result(input bit check_busy);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) return;
      if (check_busy) check("in_ready_busy", 32'(in_ready), 32'd0);
    end
    check("result_timeout", 32'(out_valid), 32'd1);
  endtask

  // Wait for the scoreboard to empty and the divider to be back in IDLE.
  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready) return;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results.
    send(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
    wait_result(1'b1);
    drain();
    @(posedge clk); #1;
    send(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    drain();
    @(posedge clk); #1;
    send(16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
    drain();
    @(posedge clk); #1;
    send(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
    drain();
    @(posedge clk); #1;
    send(16'd0, 16'd5, 16'd0, 16'd0, 1'b0);
    drain();
    @(posedge clk); #1;
    send(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    drain();
    @(posedge clk); #1;
    send(16'd9, 16'd4, 16'd2, 16'd1, 1'b0);
    drain();

    // Backpressure: result held for 5 cycles, operands offered meanwhile
    // must be ignored.
    @(negedge clk);
    bp = 1'b1;
    @(posedge clk); #1;
    send(16'd50000, 16'd123, 16'd406, 16'd62, 1'b0);
    wait_result(1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    dividend = 16'd1;
    divisor  = 16'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", 32'(quotient), 32'd406);
      check("bp_remainder", 32'(remainder), 32'd62);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    bp = 1'b0;
    drain();
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    repeat (20) @(negedge clk);   // any captured stray operand would surface here

    // Reset in the middle of a calculation.
    @(posedge clk); #1;
    send(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);   // returns at start of T+1
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;                                     // sampled at end of T+8
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    @(posedge clk); #1;
    send(16'd100, 16'd9, 16'd11, 16'd1, 1'b0);
    drain();

    // Random regression against the reference model.
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      a = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 99) == 0)     b = '0;
      else if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 255));
      else                                b = 16'($urandom_range(1, 65535));
      send_ref(a, b);
    end
    drain();
    rand_mode = 1'b0;
    repeat (5) @(negedge clk);
    check("final_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_div16_seq
